dmem_access: RTL and testbench
==============================

# dmem_access

MEM-stage data-memory access controller for the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, and drives a variable-latency data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and inserts bubbles into MEM/WB. It also performs byte/half/word lane alignment with sign/zero extension.

## Interface
- TIMEOUT, 16, maximum BUSY cycles without `mem_ack_i` before the access is abandoned (≥2)
- clk_i  in  1  clock; all state updates on the rising edge
- start_i  in  1  reset, asynchronous and active-low
- MemRead_i, MemWrite_i  in  1 each  access request from EX/MEM
- Funct3_i  in  3  load/store width code
- ALUdata_i  in  32  effective byte address; also the non-load writeback value
- WriteData_i  in  32  store data, right-aligned
- RegWrite_i, MemtoReg_i  in  1 each  writeback control from EX/MEM
- RegWaddr_i  in  5  destination register
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  write enable, registered
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}), registered
- mem_be_o  out  4  byte enables, registered
- mem_wdata_o  out  32  lane-replicated store data, registered
- mem_ack_i  in  1  one-cycle completion pulse; for reads, data is valid in the same cycle
- mem_rdata_i  in  32  read word
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational)
- RegWrite_o, MemtoReg_o  out  1 each  to MEM/WB
- ALUdata_o, ReadData_o  out  32 each  to MEM/WB
- RegWaddr_o  out  5  to MEM/WB
- fault_o  out  1  sticky: misaligned, illegal or timed-out access; cleared only by reset

## Operation
- Funct3 encodings: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
- Illegal access: any other Funct3, MemRead_i and MemWrite_i both high, half at odd address, or word with addr[1:0]≠0.
  - An illegal access sets fault_o.
  - It issues no memory request and does not stall.
  - RegWrite_o=0 that cycle.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no access: pass-through.
  - RegWrite_o/MemtoReg_o/ALUdata_o/RegWaddr_o follow their inputs.
  - ReadData_o=0; stall_o=0.
- IDLE, legal access:
  - stall_o=1 and RegWrite_o=0 (bubble).
  - Register mem_req_o=1 plus we/addr/be/wdata.
  - Next state BUSY; clear the timeout counter.
- BUSY:
  - stall_o=1, RegWrite_o=0.
  - mem_req_o and all request fields stay stable until the ack cycle.
  - mem_ack_i=1: capture the aligned/extended read data (0 for stores) into rdata_q, drop mem_req_o, go to DONE.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req_o, set fault_o, rdata_q=0, go to DONE.
- DONE:
  - stall_o=0.
  - Outputs follow EX/MEM; ReadData_o=rdata_q.
  - RegWrite_o=RegWrite_i unless a timeout occurred in this access (then 0).
  - Next state IDLE. EX/MEM advances on this edge, so IDLE sees the next instruction.
- Load extraction by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
- Store byte enables:
  - sb: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - sh: be=addr[1]?1100:0011, wdata={2{half}}.
  - sw: be=1111.

## Timing
- Reset values (start_i low): state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, rdata_q=0, counter=0, fault_o=0.
- Reset mid-BUSY aborts the access immediately; mem_req_o falls asynchronously.
- Combinational outputs (stall_o, RegWrite_o, MemtoReg_o, ALUdata_o, ReadData_o, RegWaddr_o) follow the reset state and inputs: stall_o=0, ReadData_o=0 in IDLE.
- Memory access latency is 2+N cycles of stall, where N≥0 is the number of extra BUSY cycles before ack.
  - Ack in the first BUSY cycle: IDLE, BUSY, DONE, so 2 stall cycles, then the writeback-valid cycle.
- mem_ack_i outside BUSY is ignored.
- Back-to-back memory instructions: DONE→IDLE accepts the next access with no extra gap.

## Structure
- Package `dmem_pkg`:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum {IDLE, BUSY, DONE}.
  - Default TIMEOUT.
- Sub-module `dmem_lane_align`: combinational.
  - Inputs: funct3, addr[1:0], store data, read word.
  - Outputs: be, replicated wdata, extended load data, misaligned flag.

## Test plan
- lw at 0x100, memory returns 0xDEADBEEF with ack in the first BUSY cycle → stall_o high 2 cycles; DONE cycle: RegWrite_o=1, ReadData_o=0xDEADBEEF, mem_addr_o=0x100, mem_be_o=1111.
- lb at 0x103 and lbu at 0x103, rdata 0x80FF1234 → ReadData_o 0xFFFFFF80 and 0x00000080 respectively.
- sh at 0x202, WriteData_i=0x0000ABCD, ack after 5 BUSY cycles → mem_addr_o=0x200, be=1100, wdata=0xABCDABCD, we=1; stall_o high 6 cycles; RegWrite_o=0 throughout.
- lw at 0x102 → fault_o=1 the following cycle; mem_req_o stays 0; stall_o=0; RegWrite_o=0.
- Load with no ack, TIMEOUT=16 → mem_req_o drops after 16 BUSY cycles; fault_o=1; DONE cycle has ReadData_o=0 and RegWrite_o=0.
- Reset asserted in the 3rd BUSY cycle → mem_req_o=0 immediately, fault_o=0; after release, an add passes through with stall_o=0 and RegWrite_o following RegWrite_i.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared Funct3 codes, FSM states and timeout default for dmem_access
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic f3_ok(input logic rd, input logic [2:0] f3);
    return (f3 inside {F3_B, F3_H, F3_W}) || (rd && (f3 inside {F3_BU, F3_HU}));
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane extraction/extension for loads
// funct3_i/addr_i select width and lane; wdata_i right-aligned store data; rdata_i raw read word;
// be_o byte enables, wdata_o lane-replicated store data, ldata_o extended load, misalign_o bad alignment
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);
  logic [7:0]  lb_v;
  logic [15:0] lh_v;
  always_comb begin
    lb_v = rdata_i[{addr_i, 3'b000} +: 8];
    lh_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o = funct3_i[1] ? 4'b1111 : funct3_i[0] ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_i;
    wdata_o = funct3_i[1] ? wdata_i : funct3_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    ldata_o = funct3_i == F3_B  ? {{24{lb_v[7]}}, lb_v} :
              funct3_i == F3_H  ? {{16{lh_v[15]}}, lh_v} :
              funct3_i == F3_W  ? rdata_i :
              funct3_i == F3_BU ? {24'b0, lb_v} :
              funct3_i == F3_HU ? {16'b0, lh_v} : '0;
    misalign_o = (funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i[1:0] == 2'b10 && addr_i != 2'b00);
  end
endmodule

// File: rtl/dmem_access.sv
// dmem_access: MEM-stage data-memory controller with req/ack handshake, stall and bubble insertion
// clk_i/start_i clock and async active-low reset; *_i from EX/MEM; mem_* memory port (registered);
// stall_o freezes the front of the pipe; RegWrite_o..RegWaddr_o to MEM/WB; fault_o sticky error
module dmem_access
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] WriteData_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [4:0]  RegWaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUdata_o,
  output logic [31:0] ReadData_o,
  output logic [4:0]  RegWaddr_o,
  output logic        fault_o
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, fault_q, fault_d, to_q, to_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] al_be;
  logic [31:0] al_wdata, al_ldata;
  logic al_mis, access, illegal;
  dmem_lane_align u_align (
    .funct3_i  (Funct3_i),
    .addr_i    (ALUdata_i[1:0]),
    .wdata_i   (WriteData_i),
    .rdata_i   (mem_rdata_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ldata_o   (al_ldata),
    .misalign_o(al_mis)
  );
  assign access  = MemRead_i || MemWrite_i;
  assign illegal = access && ((MemRead_i && MemWrite_i) || !f3_ok(MemRead_i, Funct3_i) || al_mis);
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign fault_o     = fault_q;
  assign MemtoReg_o  = MemtoReg_i;
  assign ALUdata_o   = ALUdata_i;
  assign RegWaddr_o  = RegWaddr_i;
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    to_d       = to_q;
    stall_o    = 1'b0;
    RegWrite_o = RegWrite_i;
    ReadData_o = '0;
    case (state_q)
      IDLE: begin
        if (illegal) begin
          fault_d    = 1'b1;
          RegWrite_o = 1'b0;
        end else if (access) begin
          stall_o    = 1'b1;
          RegWrite_o = 1'b0;
          req_d      = 1'b1;
          we_d       = MemWrite_i;
          addr_d     = {ALUdata_i[31:2], 2'b00};
          be_d       = al_be;
          wdata_d    = al_wdata;
          cnt_d      = '0;
          to_d       = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        stall_o    = 1'b1;
        RegWrite_o = 1'b0;
        if (mem_ack_i) begin
          rdata_d = MemWrite_i ? '0 : al_ldata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          req_d   = 1'b0;
          fault_d = 1'b1;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ReadData_o = rdata_q;
        RegWrite_o = RegWrite_i && !to_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed scoreboard bench for dmem_access with a latency-programmable memory
module tb_dmem_access;
  import dmem_pkg::*;
  logic        clk_i = 1'b0;
  logic        start_i = 1'b0;
  logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, RegWrite_i = 1'b0, MemtoReg_i = 1'b0;
  logic [2:0]  Funct3_i = '0;
  logic [31:0] ALUdata_i = '0, WriteData_i = '0;
  logic [4:0]  RegWaddr_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o, fault_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ALUdata_o, ReadData_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  RegWaddr_o;
  localparam int TO = 16;
  typedef struct {
    logic [31:0] rdata;
    logic        rw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          stalls;
    int          reqs;
  } exp_t;
  exp_t sb_q[$];
  int total = 0, bad = 0, lat = 0, bc = 0;
  dmem_access #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .start_i(start_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Funct3_i(Funct3_i), .ALUdata_i(ALUdata_i), .WriteData_i(WriteData_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .RegWaddr_i(RegWaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALUdata_o(ALUdata_o),
    .ReadData_o(ReadData_o), .RegWaddr_o(RegWaddr_o), .fault_o(fault_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
    if (mem_req_o && !mem_ack_i) begin
      bc++;
      mem_ack_i = (lat != 0) && (bc == lat);
    end else begin
      mem_ack_i = 1'b0;
      bc = 0;
    end
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic rw);
    MemRead_i = rd;
    MemWrite_i = wr;
    Funct3_i = f3;
    ALUdata_i = a;
    WriteData_i = wd;
    RegWrite_i = rw;
    MemtoReg_i = rd;
    RegWaddr_i = 5'd7;
  endtask
  task automatic do_reset();
    start_i = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    start_i = 1'b1;
  endtask
  task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int l, input logic [31:0] er, input logic erw, input logic [31:0] ea,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    exp_t e, x;
    int n, r;
    logic bub, uns, first;
    logic [31:0] ca, cw;
    logic [3:0] cb;
    logic cwe;
    step();
    lat = l;
    mem_rdata_i = word;
    drive(rd, wr, f3, a, wd, rd);
    e.rdata = er; e.rw = erw; e.addr = ea; e.be = ebe; e.wdata = ewd; e.we = wr;
    e.stalls = (l == 0) ? TO + 1 : l + 1;
    e.reqs = e.stalls - 1;
    sb_q.push_back(e);
    #1;
    n = 0; r = 0; bub = 1'b0; uns = 1'b0; first = 1'b1;
    ca = '0; cw = '0; cb = '0; cwe = 1'b0;
    while (stall_o && n < 100) begin
      n++;
      if (RegWrite_o) bub = 1'b1;
      if (mem_req_o) begin
        r++;
        if (first) begin
          ca = mem_addr_o; cb = mem_be_o; cw = mem_wdata_o; cwe = mem_we_o; first = 1'b0;
        end else if (mem_addr_o !== ca || mem_be_o !== cb || mem_wdata_o !== cw || mem_we_o !== cwe) begin
          uns = 1'b1;
        end
      end
      step();
      #1;
    end
    x = sb_q.pop_front();
    chk({nm, ".stalls"}, 32'(n), 32'(x.stalls));
    chk({nm, ".reqs"}, 32'(r), 32'(x.reqs));
    chk({nm, ".bubble"}, {31'b0, bub}, 32'd0);
    chk({nm, ".stable"}, {31'b0, uns}, 32'd0);
    chk({nm, ".addr"}, ca, x.addr);
    chk({nm, ".be"}, {28'b0, cb}, {28'b0, x.be});
    chk({nm, ".wdata"}, cw, x.wdata);
    chk({nm, ".we"}, {31'b0, cwe}, {31'b0, x.we});
    chk({nm, ".rdata"}, ReadData_o, x.rdata);
    chk({nm, ".regwrite"}, {31'b0, RegWrite_o}, {31'b0, x.rw});
  endtask
  initial begin
    do_reset();
    #1;
    chk("rst.stall", {31'b0, stall_o}, 32'd0);
    chk("rst.req", {31'b0, mem_req_o}, 32'd0);
    chk("rst.we", {31'b0, mem_we_o}, 32'd0);
    chk("rst.addr", mem_addr_o, 32'h0);
    chk("rst.be", {28'b0, mem_be_o}, 32'h0);
    chk("rst.wdata", mem_wdata_o, 32'h0);
    chk("rst.fault", {31'b0, fault_o}, 32'd0);
    chk("rst.rdata", ReadData_o, 32'h0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1);
    mem_ack_i = 1'b1;
    #1;
    chk("pass.stall", {31'b0, stall_o}, 32'd0);
    chk("pass.rw", {31'b0, RegWrite_o}, 32'd1);
    chk("pass.alu", ALUdata_o, 32'h0000_1234);
    chk("pass.waddr", {27'b0, RegWaddr_o}, 32'd7);
    chk("pass.rdata", ReadData_o, 32'h0);
    step();
    #1;
    chk("stray_ack.req", {31'b0, mem_req_o}, 32'd0);
    chk("stray_ack.stall", {31'b0, stall_o}, 32'd0);
    access("lw100", 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 1,
           32'hDEAD_BEEF, 1'b1, 32'h100, 4'b1111, 32'h0);
    access("lb103", 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_1234, 1,
           32'hFFFF_FF80, 1'b1, 32'h100, 4'b1000, 32'h0);
    access("lbu103", 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_1234, 3,
           32'h0000_0080, 1'b1, 32'h100, 4'b1000, 32'h0);
    access("lh102", 1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h80FF_1234, 2,
           32'hFFFF_80FF, 1'b1, 32'h100, 4'b1100, 32'h0);
    access("lhu100", 1'b1, 1'b0, F3_HU, 32'h100, 32'h0, 32'h80FF_9234, 1,
           32'h0000_9234, 1'b1, 32'h100, 4'b0011, 32'h0);
    access("sh202", 1'b0, 1'b1, F3_H, 32'h202, 32'h0000_ABCD, 32'h0, 5,
           32'h0, 1'b0, 32'h200, 4'b1100, 32'hABCD_ABCD);
    access("sb301", 1'b0, 1'b1, F3_B, 32'h301, 32'h0000_00A5, 32'h0, 2,
           32'h0, 1'b0, 32'h300, 4'b0010, 32'hA5A5_A5A5);
    access("sw400", 1'b0, 1'b1, F3_W, 32'h400, 32'h1234_5678, 32'h0, 1,
           32'h0, 1'b0, 32'h400, 4'b1111, 32'h1234_5678);
    chk("legal.fault", {31'b0, fault_o}, 32'd0);
    step();
    drive(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 1'b1);
    #1;
    chk("mis.stall", {31'b0, stall_o}, 32'd0);
    chk("mis.rw", {31'b0, RegWrite_o}, 32'd0);
    chk("mis.fault_pre", {31'b0, fault_o}, 32'd0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    #1;
    chk("mis.fault", {31'b0, fault_o}, 32'd1);
    chk("mis.req", {31'b0, mem_req_o}, 32'd0);
    do_reset();
    #1;
    chk("rst2.fault", {31'b0, fault_o}, 32'd0);
    step();
    drive(1'b0, 1'b1, 3'b100, 32'h500, 32'h0, 1'b0);
    #1;
    chk("badf3.stall", {31'b0, stall_o}, 32'd0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    #1;
    chk("badf3.fault", {31'b0, fault_o}, 32'd1);
    chk("badf3.req", {31'b0, mem_req_o}, 32'd0);
    do_reset();
    access("timeout", 1'b1, 1'b0, F3_W, 32'h600, 32'h0, 32'h5555_5555, 0,
           32'h0, 1'b0, 32'h600, 4'b1111, 32'h0);
    chk("timeout.fault", {31'b0, fault_o}, 32'd1);
    step();
    lat = 0;
    drive(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 1'b1);
    repeat (3) step();
    #1;
    chk("midbusy.req_pre", {31'b0, mem_req_o}, 32'd1);
    start_i = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    #1;
    chk("midbusy.req", {31'b0, mem_req_o}, 32'd0);
    chk("midbusy.fault", {31'b0, fault_o}, 32'd0);
    chk("midbusy.addr", mem_addr_o, 32'h0);
    step();
    start_i = 1'b1;
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'h0, 1'b1);
    #1;
    chk("add.stall", {31'b0, stall_o}, 32'd0);
    chk("add.rw", {31'b0, RegWrite_o}, 32'd1);
    chk("add.alu", ALUdata_o, 32'h0000_00AA);
    step();
    RegWrite_i = 1'b0;
    #1;
    chk("add.rw0", {31'b0, RegWrite_o}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
